// File: rtl/nibble_serial_addsub_ctrl_if.sv
// Bundle between the ALU front-end, the nibble sequencer and the shared 4-bit add/sub unit.
// slave = sequencer side; master = front-end plus unit side.
interface nibble_serial_addsub_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         sel;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic         add_sel;
  logic [3:0]   add_s;
  logic         add_cout;

  modport slave (
    input  start, sel, a, b, cin, add_s, add_cout,
    output busy, done, result, cout, ovf, add_a, add_b, add_cin, add_sel
  );

  modport master (
    output start, sel, a, b, cin, add_s, add_cout,
    input  busy, done, result, cout, ovf, add_a, add_b, add_cin, add_sel
  );
endinterface

// File: rtl/nibble_serial_addsub_ctrl.sv
// Runs W-bit add/sub on a shared 4-bit unit, LSB nibble first; done NIBBLES+1 edges after start.
// No backpressure: start is taken only in IDLE/DONE and silently ignored while busy.
module nibble_serial_addsub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  nibble_serial_addsub_ctrl_if.slave    bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic          r_carry;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_sel;
  logic [W-1:0]  r_result;
  logic          r_cout;
  logic          r_ovf;
  logic          r_done;

  logic          w_run;
  logic [IW+1:0] w_pos;
  logic [3:0]    w_a_nib;
  logic [3:0]    w_b_nib;
  logic          w_bm;
  logic          w_ovf;

  assign w_run   = (r_state == S_RUN);
  assign w_pos   = {r_idx, 2'b00};
  assign w_a_nib = r_a[w_pos +: 4];
  assign w_b_nib = r_b[w_pos +: 4];

  // Overflow uses the effective (possibly inverted) B sign bit, as the unit sees it.
  assign w_bm  = r_sel ? ~r_b[W-1] : r_b[W-1];
  assign w_ovf = (r_a[W-1] == w_bm) && (bus.add_s[3] != r_a[W-1]);

  assign bus.add_a   = w_run ? w_a_nib : 4'd0;
  assign bus.add_b   = w_run ? w_b_nib : 4'd0;
  assign bus.add_cin = w_run ? r_carry : 1'b0;
  assign bus.add_sel = w_run ? r_sel   : 1'b0;

  assign bus.busy   = w_run;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.cout   = r_cout;
  assign bus.ovf    = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_sel    <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_RUN: begin
          r_result[w_pos +: 4] <= bus.add_s;
          r_carry              <= bus.add_cout;
          r_idx                <= r_idx + IW'(1);
          if (r_idx == LAST) begin
            r_state <= S_DONE;
            r_idx   <= '0;
            r_cout  <= bus.add_cout;
            r_ovf   <= w_ovf;
            r_done  <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE accept start identically, giving back-to-back issue from DONE.
          if (bus.start) begin
            r_state <= S_RUN;
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_sel   <= bus.sel;
            r_idx   <= '0;
            r_carry <= bus.sel ? ~bus.cin : bus.cin;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_serial_addsub_ctrl.sv
// Directed bench for nibble_serial_addsub_ctrl with NIBBLES=4 and a behavioural 4-bit add/sub unit.
module tb_nibble_serial_addsub_ctrl;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  nibble_serial_addsub_ctrl_if #(.NIBBLES(4)) bus ();

  nibble_serial_addsub_ctrl #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [4:0] unit_sum;
  assign unit_sum     = {1'b0, bus.add_a} + {1'b0, (bus.add_sel ? ~bus.add_b : bus.add_b)}
                      + {4'd0, bus.add_cin};
  assign bus.add_s    = unit_sum[3:0];
  assign bus.add_cout = unit_sum[4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sel;
    logic        cin;
    logic [15:0] res;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic s, input logic c);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    bus.sel   = s;
    bus.cin   = c;
  endtask

  // Counts rising edges (including the one that samples start) until done is seen.
  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = 16'hDEAD;
      bus.b     = 16'hBEEF;
      edges++;
      @(negedge clk);
    end while (!bus.done && edges < 20);
  endtask

  initial begin
    int          edges;
    logic [15:0] av;
    n_chk  = 0;
    n_fail = 0;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0002, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
    vecs[4] = '{16'h0001, 16'h0002, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[5] = '{16'h0005, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[7] = '{16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0};
    vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    rst_n = 1'b0;
    launch(16'h0, 16'h0, 1'b0, 1'b0);
    bus.start = 1'b0;
    #3;
    chk("rst_busy",   32'(bus.busy),   32'h0);
    chk("rst_done",   32'(bus.done),   32'h0);
    chk("rst_result", 32'(bus.result), 32'h0);
    chk("rst_cout",   32'(bus.cout),   32'h0);
    chk("rst_ovf",    32'(bus.ovf),    32'h0);
    chk("rst_add_a",  32'(bus.add_a),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Nibble sequence presented to the shared unit, LSB first.
    av = 16'h1234;
    launch(av, 16'h0FFF, 1'b0, 1'b0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("seq_add_a%0d", i), 32'(bus.add_a), 32'(av[4*i +: 4]));
      chk($sformatf("seq_busy%0d", i),  32'(bus.busy),  32'h1);
    end
    @(negedge clk);
    chk("seq_done",   32'(bus.done),   32'h1);
    chk("seq_result", 32'(bus.result), 32'h2233);
    chk("seq_idle_add_a", 32'(bus.add_a), 32'h0);
    @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      launch(vecs[v].a, vecs[v].b, vecs[v].sel, vecs[v].cin);
      wait_done(edges);
      chk($sformatf("v%0d_latency", v), 32'(edges),         32'd5);
      chk($sformatf("v%0d_result", v),  32'(bus.result),    32'(vecs[v].res));
      chk($sformatf("v%0d_cout", v),    32'(bus.cout),      32'(vecs[v].co));
      chk($sformatf("v%0d_ovf", v),     32'(bus.ovf),       32'(vecs[v].ov));
      @(negedge clk);
      chk($sformatf("v%0d_done_width", v), 32'(bus.done),   32'h0);
      chk($sformatf("v%0d_hold", v),       32'(bus.result), 32'(vecs[v].res));
    end

    // Reset mid-RUN: cout/ovf are 1 from the last vector, so clearing is observable.
    launch(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid_partial", 32'(bus.result), 32'h0045);
    chk("mid_busy",    32'(bus.busy),   32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy",   32'(bus.busy),   32'h0);
    chk("arst_done",   32'(bus.done),   32'h0);
    chk("arst_result", 32'(bus.result), 32'h0);
    chk("arst_cout",   32'(bus.cout),   32'h0);
    chk("arst_ovf",    32'(bus.ovf),    32'h0);
    repeat (3) @(negedge clk);
    chk("arst_no_done", 32'(bus.done), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    launch(16'h1234, 16'h1111, 1'b0, 1'b0);
    wait_done(edges);
    chk("post_rst_latency", 32'(edges),      32'd5);
    chk("post_rst_result",  32'(bus.result), 32'h2345);
    @(negedge clk);

    // Start while busy is dropped.
    launch(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    #1 launch(16'h1111, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(edges);
    chk("ign_remaining", 32'(edges),      32'd2);
    chk("ign_result",    32'(bus.result), 32'h2233);
    @(negedge clk);
    chk("ign_no_rerun",  32'(bus.busy),   32'h0);
    chk("ign_done_low",  32'(bus.done),   32'h0);

    // Back-to-back: start in the DONE cycle.
    launch(16'h0002, 16'h0001, 1'b1, 1'b0);
    wait_done(edges);
    chk("b2b_first_result", 32'(bus.result), 32'h0001);
    chk("b2b_first_cout",   32'(bus.cout),   32'h1);
    launch(16'h0005, 16'h0003, 1'b0, 1'b0);
    wait_done(edges);
    chk("b2b_latency", 32'(edges),      32'd5);
    chk("b2b_result",  32'(bus.result), 32'h0008);
    chk("b2b_cout",    32'(bus.cout),   32'h0);
    chk("b2b_ovf",     32'(bus.ovf),    32'h0);
    @(negedge clk);
    chk("b2b_done_width", 32'(bus.done), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
